// File: rtl/mem_bridge_if.sv
// Bus interfaces around mem_bridge: the CPU data-memory port and the
// external variable-latency data-memory port.

interface cpu_bus_if #(
  parameter int Dbits = 32
);
  logic             cpu_req;
  logic             cpu_wr;
  logic [31:0]      cpu_addr;
  logic [Dbits-1:0] cpu_wdata;
  logic [Dbits-1:0] cpu_rdata;
  logic             cpu_enable;

  modport master (output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
                  input  cpu_rdata, cpu_enable);
  modport slave  (input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
                  output cpu_rdata, cpu_enable);
endinterface

interface dmem_bus_if #(
  parameter int Dbits  = 32,
  parameter int AWIDTH = 10
);
  logic              dmem_req;
  logic              dmem_wr;
  logic [AWIDTH-1:0] dmem_addr;
  logic [Dbits-1:0]  dmem_wdata;
  logic [Dbits-1:0]  dmem_rdata;
  logic              dmem_ack;

  modport master (output dmem_req, dmem_wr, dmem_addr, dmem_wdata,
                  input  dmem_rdata, dmem_ack);
  modport slave  (input  dmem_req, dmem_wr, dmem_addr, dmem_wdata,
                  output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_bridge.sv
// Routes CPU loads/stores to external data memory (stalling until ack or
// timeout) or to zero-wait memory-mapped I/O registers.
//
// state  | meaning
// S_IDLE | no memory access in flight; I/O and errors complete here
// S_WAIT | memory request issued, waiting for ack or timeout
// S_DONE | return captured read data, release the stall for one cycle

module mem_bridge #(
  parameter int Dbits   = 32,
  parameter int AWIDTH  = 10,
  parameter int LEDW    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  cpu_bus_if.slave        cpu,
  dmem_bus_if.master      dmem,
  input  logic [15:0]     i_switches,
  output logic [LEDW-1:0] o_leds,
  output logic            o_bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_wcnt;
  logic [AWIDTH-1:0] r_addr;
  logic              r_wr;
  logic [Dbits-1:0]  r_wdata;
  logic [Dbits-1:0]  r_rdata_q;
  logic [LEDW-1:0]   r_leds;
  logic [31:0]       r_cycle;
  logic              r_bus_err;

  logic              w_aligned, w_in_mem, w_is_led, w_is_cnt, w_is_sw;
  logic              w_mem_go, w_bad, w_led_we, w_timeout;
  logic [Dbits-1:0]  w_io_rdata;
  logic              w_dmem_req, w_dmem_wr, w_cpu_en;
  logic [AWIDTH-1:0] w_dmem_addr;
  logic [Dbits-1:0]  w_dmem_wdata, w_cpu_rdata;

  assign w_aligned = (cpu.cpu_addr[1:0] == 2'b00);
  assign w_in_mem  = (cpu.cpu_addr[31:16] == 16'h1001);
  assign w_is_led  = (cpu.cpu_addr == 32'h1003_0000);
  assign w_is_cnt  = (cpu.cpu_addr == 32'h1003_0004);
  assign w_is_sw   = (cpu.cpu_addr == 32'h1003_0008);
  assign w_mem_go  = cpu.cpu_req && w_aligned && w_in_mem;
  assign w_bad     = cpu.cpu_req &&
                     !(w_aligned && (w_in_mem || w_is_led || w_is_cnt || w_is_sw));
  assign w_led_we  = (r_state == S_IDLE) && cpu.cpu_req && cpu.cpu_wr && w_is_led;
  assign w_timeout = (r_wcnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_io_rdata = '0;
    if (w_is_led)      w_io_rdata = Dbits'(r_leds);
    else if (w_is_cnt) w_io_rdata = Dbits'(r_cycle);
    else if (w_is_sw)  w_io_rdata = Dbits'(i_switches);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dmem_req   = 1'b0;
    w_dmem_wr    = 1'b0;
    w_dmem_addr  = r_addr;
    w_dmem_wdata = r_wdata;
    w_cpu_en     = 1'b0;
    w_cpu_rdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_go) begin
          w_dmem_req   = 1'b1;
          w_dmem_wr    = cpu.cpu_wr;
          w_dmem_addr  = cpu.cpu_addr[AWIDTH+1:2];
          w_dmem_wdata = cpu.cpu_wdata;
          w_state_nxt  = S_WAIT;
        end else begin
          w_cpu_en    = 1'b1;
          w_cpu_rdata = w_io_rdata;
        end
      end
      S_WAIT: begin
        w_dmem_wr = r_wr;
        if (dmem.dmem_ack || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_cpu_en    = 1'b1;
        w_cpu_rdata = r_rdata_q;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_rdata_q <= '0;
      r_leds    <= '0;
      r_cycle   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_led_we) r_leds <= cpu.cpu_wdata[LEDW-1:0];
      case (r_state)
        S_IDLE: begin
          if (w_bad) r_bus_err <= 1'b1;
          if (w_mem_go) begin
            r_addr  <= cpu.cpu_addr[AWIDTH+1:2];
            r_wr    <= cpu.cpu_wr;
            r_wdata <= cpu.cpu_wdata;
            r_wcnt  <= '0;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_ack) begin
            r_rdata_q <= r_wr ? '0 : dmem.dmem_rdata;
          end else if (w_timeout) begin
            r_rdata_q <= Dbits'(32'hDEAD_BEEF);
            r_bus_err <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Reset must silence the bus and hold the CPU even before the first edge.
  assign dmem.dmem_req   = w_dmem_req & ~rst;
  assign dmem.dmem_wr    = w_dmem_wr & ~rst;
  assign dmem.dmem_addr  = w_dmem_addr;
  assign dmem.dmem_wdata = w_dmem_wdata;
  assign cpu.cpu_enable  = w_cpu_en & ~rst;
  assign cpu.cpu_rdata   = w_cpu_rdata;
  assign o_leds          = r_leds;
  assign o_bus_err       = r_bus_err;

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the CPU datapath's data-memory port.
- Consumes the datapath's load/store address, write data and access strobes.
- Routes each access to either an external data memory with a variable-latency valid/ack handshake, or a small bank of memory-mapped I/O registers.
- Stalls the datapath through its enable input until the access completes; returns read data on the same cycle the stall is released.

Parameters:
- Dbits, 32, data width of the CPU and the data memory.
- AWIDTH, 10, data-memory word-address width.
- LEDW, 16, width of the LED output register.
- TIMEOUT, 15, maximum wait cycles for dmem_ack before the access is aborted.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  current instruction is a load or store
- cpu_wr  in  1  1 = store, 0 = load; qualified by cpu_req
- cpu_addr  in  32  byte address (datapath mem_addr)
- cpu_wdata  in  Dbits  store data
- cpu_rdata  out  Dbits  load data (to datapath mem_readdata)
- cpu_enable  out  1  datapath/PC enable; 0 = stall
- dmem_req  out  1  memory request pulse
- dmem_wr  out  1  memory write
- dmem_addr  out  AWIDTH  word address, cpu_addr[AWIDTH+1:2]
- dmem_wdata  out  Dbits  memory write data
- dmem_rdata  in  Dbits  memory read data, valid with dmem_ack
- dmem_ack  in  1  access complete
- switches  in  16  raw switch inputs
- leds  out  LEDW  LED register
- bus_err  out  1  sticky error flag

Behaviour:
- Address map:
  - 0x1001_xxxx: data memory; bits [15:AWIDTH+2] ignored, so addresses alias.
  - 0x1003_0000: LED register, read/write; reads return zero-extended leds.
  - 0x1003_0004: cycle counter, read-only; writes ignored.
  - 0x1003_0008: switches, read-only, zero-extended.
  - Any other address: reads return 0, writes ignored, bus_err set.
- Misaligned access (cpu_addr[1:0] != 0) with cpu_req=1: no memory or I/O side effect, read returns 0, bus_err set, completes with zero wait.
- I/O and error accesses:
  - Zero wait; cpu_enable stays 1.
  - cpu_rdata is combinational from the address.
  - I/O writes commit at the same posedge the PC advances.
- FSM states: IDLE, WAIT, DONE. Reset enters IDLE.
  - IDLE: if cpu_req and address is in the data-memory region:
    - drive dmem_req=1 (with dmem_wr, dmem_addr, dmem_wdata) for exactly this cycle;
    - cpu_enable=0;
    - go to WAIT and clear the wait counter.
    - Otherwise cpu_enable=1.
  - WAIT:
    - cpu_enable=0, dmem_req=0; dmem_addr, dmem_wr and dmem_wdata are held from registered copies.
    - On dmem_ack: capture dmem_rdata into rdata_q (stores capture 0) and go to DONE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT without an ack: rdata_q=0xDEAD_BEEF, set bus_err, go to DONE.
  - DONE: cpu_enable=1, cpu_rdata=rdata_q, then IDLE unconditionally. cpu_req is not re-sampled in DONE, so the same instruction never issues twice.
- dmem_ack is ignored in IDLE and DONE, including a late ack after timeout or reset.
- Memory latency: an access with an ack N cycles after dmem_req stalls the CPU for N+1 cycles. The minimum is N=1, giving 2 stall cycles.
- Cycle counter:
  - 32-bit, increments every clk while not in reset; wraps 0xFFFF_FFFF -> 0.
  - A read returns the value on the cycle cpu_enable=1.
- Reset values:
  - FSM=IDLE, leds=0, counter=0, bus_err=0, rdata_q=0, dmem_req=0, dmem_wr=0.
  - cpu_enable=0 while reset is high.
- Reset mid-WAIT: state immediately returns to IDLE and dmem_req is dropped; the pending access is abandoned.
- bus_err clears only on reset.

Test Plan:
- Store 0x1234_5678 to 0x1001_0010, ack 3 cycles after dmem_req -> dmem_addr=4, dmem_wr=1, dmem_req high exactly 1 cycle, cpu_enable low 4 cycles.
- Load from 0x1001_0010, ack with 0xCAFE_F00D 1 cycle later -> cpu_rdata=0xCAFE_F00D in the cycle cpu_enable returns to 1, no second dmem_req.
- Store 0x0000_ABCD to 0x1003_0000, then load the same address -> leds=0xABCD after the store edge, no stall, read returns 0x0000_ABCD; load 0x1003_0008 with switches=0x00F0 -> 0x0000_00F0.
- Load 0x1001_0000 with no ack -> stall of TIMEOUT+1 cycles, cpu_rdata=0xDEAD_BEEF, bus_err=1; a later ack is ignored.
- Access 0x1001_0002 and 0x2000_0000 -> no dmem_req, bus_err=1, zero stall, read data 0.
- Assert reset during WAIT -> cpu_enable=0, dmem_req=0, leds=0, counter=0 asynchronously; after release, a new load issues normally.
